// File: rtl/trivium_parallel.sv
// Trivium keystream generator advancing the 288-bit state OUT_WIDTH steps per clock.
// Init loads key/IV, a fixed warm-up runs blank rounds, then words stream out under valid/ready.
module trivium_parallel #(
  parameter int unsigned OUT_WIDTH     = 8,
  parameter int unsigned WARMUP_ROUNDS = 1152
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init,
  input  logic [79:0]          key,
  input  logic [79:0]          iv,
  output logic                 busy,
  output logic                 ks_valid,
  input  logic                 ks_ready,
  output logic [OUT_WIDTH-1:0] ks_data
);

  localparam int unsigned A_W         = 93;
  localparam int unsigned B_W         = 84;
  localparam int unsigned C_W         = 111;
  localparam int unsigned WARM_CYCLES = WARMUP_ROUNDS / OUT_WIDTH;
  localparam int unsigned CNT_W       = $clog2(WARM_CYCLES + 1);
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARM_CYCLES - 1);

  // Tap positions (0-based within each register; s66 of the state is a[65], etc.)
  localparam int unsigned A_OUT  = 65;
  localparam int unsigned A_LAST = 92;
  localparam int unsigned A_AND0 = 90;
  localparam int unsigned A_AND1 = 91;
  localparam int unsigned A_FB   = 68;
  localparam int unsigned B_OUT  = 68;
  localparam int unsigned B_LAST = 83;
  localparam int unsigned B_AND0 = 81;
  localparam int unsigned B_AND1 = 82;
  localparam int unsigned B_FB   = 77;
  localparam int unsigned C_OUT  = 65;
  localparam int unsigned C_LAST = 110;
  localparam int unsigned C_AND0 = 108;
  localparam int unsigned C_AND1 = 109;
  localparam int unsigned C_FB   = 86;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [A_W-1:0]   a_q, a_d, a_step;
  logic [B_W-1:0]   b_q, b_d, b_step;
  logic [C_W-1:0]   c_q, c_d, c_step;
  logic             busy_d, valid_d;
  logic             t1, t2, t3;

  // OUT_WIDTH cascaded single steps; ks_data collects the output bit of each, earliest at the MSB
  always_comb begin
    a_step  = a_q;
    b_step  = b_q;
    c_step  = c_q;
    ks_data = '0;
    t1      = 1'b0;
    t2      = 1'b0;
    t3      = 1'b0;
    for (int j = 0; j < int'(OUT_WIDTH); j++) begin
      t1 = a_step[A_OUT] ^ a_step[A_LAST];
      t2 = b_step[B_OUT] ^ b_step[B_LAST];
      t3 = c_step[C_OUT] ^ c_step[C_LAST];
      ks_data[int'(OUT_WIDTH) - 1 - j] = t1 ^ t2 ^ t3;
      t1 = t1 ^ (a_step[A_AND0] & a_step[A_AND1]) ^ b_step[B_FB];
      t2 = t2 ^ (b_step[B_AND0] & b_step[B_AND1]) ^ c_step[C_FB];
      t3 = t3 ^ (c_step[C_AND0] & c_step[C_AND1]) ^ a_step[A_FB];
      a_step = {a_step[A_W-2:0], t3};
      b_step = {b_step[B_W-2:0], t1};
      c_step = {c_step[C_W-2:0], t2};
    end
  end

  // Next-state: init always wins and discards any concurrent handshake
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    if (init) begin
      state_d = WARMUP;
      cnt_d   = '0;
      a_d     = {13'b0, key};
      b_d     = {4'b0, iv};
      c_d     = {3'b111, 108'b0};
    end else begin
      case (state_q)
        IDLE: ;
        WARMUP: begin
          a_d   = a_step;
          b_d   = b_step;
          c_d   = c_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == WARM_LAST) state_d = RUN;
        end
        RUN: begin
          if (ks_ready) begin
            a_d = a_step;
            b_d = b_step;
            c_d = c_step;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d  = (state_d == WARMUP);
    valid_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      busy     <= 1'b0;
      ks_valid <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      busy     <= busy_d;
      ks_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_trivium_parallel.sv
// Bench for trivium_parallel: five width/warm-up variants checked against a bit-serial Trivium model.
module tb_trivium_parallel;

  logic        clk = 1'b0;
  logic        rst;
  logic        init;
  logic [79:0] key, iv;

  logic        bsy [5];
  logic        val [5];
  logic        rdy [5];
  logic [63:0] dat [5];

  logic [7:0]  d8;
  logic        d1;
  logic [15:0] d16;
  logic [63:0] d64, ds;

  int checks = 0;
  int errors = 0;

  logic [1023:0] ref_long, ref_short;

  int wd   [5] = '{8, 1, 16, 64, 64};
  int wexp [5] = '{144, 1152, 72, 18, 1};

  always #5 clk = ~clk;

  trivium_parallel #(.OUT_WIDTH(8),  .WARMUP_ROUNDS(1152)) dut8 (
    .clk(clk), .rst(rst), .init(init), .key(key), .iv(iv), .busy(bsy[0]),
    .ks_valid(val[0]), .ks_ready(rdy[0]), .ks_data(d8));
  trivium_parallel #(.OUT_WIDTH(1),  .WARMUP_ROUNDS(1152)) dut1 (
    .clk(clk), .rst(rst), .init(init), .key(key), .iv(iv), .busy(bsy[1]),
    .ks_valid(val[1]), .ks_ready(rdy[1]), .ks_data(d1));
  trivium_parallel #(.OUT_WIDTH(16), .WARMUP_ROUNDS(1152)) dut16 (
    .clk(clk), .rst(rst), .init(init), .key(key), .iv(iv), .busy(bsy[2]),
    .ks_valid(val[2]), .ks_ready(rdy[2]), .ks_data(d16));
  trivium_parallel #(.OUT_WIDTH(64), .WARMUP_ROUNDS(1152)) dut64 (
    .clk(clk), .rst(rst), .init(init), .key(key), .iv(iv), .busy(bsy[3]),
    .ks_valid(val[3]), .ks_ready(rdy[3]), .ks_data(d64));
  trivium_parallel #(.OUT_WIDTH(64), .WARMUP_ROUNDS(64)) dut_short (
    .clk(clk), .rst(rst), .init(init), .key(key), .iv(iv), .busy(bsy[4]),
    .ks_valid(val[4]), .ks_ready(rdy[4]), .ks_data(ds));

  assign dat[0] = 64'(d8);
  assign dat[1] = 64'(d1);
  assign dat[2] = 64'(d16);
  assign dat[3] = d64;
  assign dat[4] = ds;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bit-serial reference with the state held as s[1..288]
  function automatic logic [1023:0] ref_stream(input logic [79:0] k, input logic [79:0] v,
                                               input int warm);
    logic [288:1]  s;
    logic [1023:0] r;
    logic          a1, a2, a3;
    s = '0;
    r = '0;
    for (int i = 1; i <= 80; i++) begin
      s[i]      = k[i-1];
      s[93 + i] = v[i-1];
    end
    s[286] = 1'b1;
    s[287] = 1'b1;
    s[288] = 1'b1;
    for (int n = 0; n < warm + 1024; n++) begin
      a1 = s[66] ^ s[93];
      a2 = s[162] ^ s[177];
      a3 = s[243] ^ s[288];
      if (n >= warm) r[n - warm] = a1 ^ a2 ^ a3;
      a1 = a1 ^ (s[91] & s[92]) ^ s[171];
      a2 = a2 ^ (s[175] & s[176]) ^ s[264];
      a3 = a3 ^ (s[286] & s[287]) ^ s[69];
      s = {s[287:178], a2, s[176:94], a1, s[92:1], a3};
    end
    return r;
  endfunction

  function automatic logic [63:0] exp_word(input logic [1023:0] r, input int pos, input int w);
    logic [63:0] e;
    e = '0;
    for (int j = 0; j < w; j++) e[w-1-j] = r[pos + j];
    return e;
  endfunction

  // Called on a falling edge: one-cycle init pulse, returns on the falling edge after the load edge
  task automatic start(input logic [79:0] k, input logic [79:0] v);
    ref_long  = ref_stream(k, v, 1152);
    ref_short = ref_stream(k, v, 64);
    key  = k;
    iv   = v;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
  endtask

  // Collects 1024 bits from every variant, counting warm-up cycles and checking stalls
  task automatic collect(input bit rnd);
    int          pos  [5];
    int          bcnt [5];
    logic [63:0] prev [5];
    bit          hold [5];
    bit          done;
    int          cyc;
    for (int d = 0; d < 5; d++) begin
      pos[d] = 0; bcnt[d] = 0; prev[d] = '0; hold[d] = 1'b0;
    end
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 4000) begin
      for (int d = 0; d < 5; d++) rdy[d] = 1'b1;
      if (rnd) rdy[0] = 1'($urandom_range(0, 1));
      key = 80'({$urandom, $urandom, $urandom});
      iv  = 80'({$urandom, $urandom, $urandom});
      done = 1'b1;
      for (int d = 0; d < 5; d++) begin
        if (bsy[d]) bcnt[d]++;
        if (hold[d]) check($sformatf("stall%0d", d), dat[d], prev[d]);
        if (val[d] && rdy[d] && pos[d] < 1024) begin
          check($sformatf("word%0d_%0d", d, pos[d]), dat[d],
                exp_word((d == 4) ? ref_short : ref_long, pos[d], wd[d]));
          pos[d] += wd[d];
        end
        hold[d] = val[d] && !rdy[d];
        prev[d] = dat[d];
        if (pos[d] < 1024) done = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    for (int d = 0; d < 5; d++) begin
      check($sformatf("warm%0d", d), 64'(bcnt[d]), 64'(wexp[d]));
      check($sformatf("done%0d", d), 64'(pos[d] >= 1024), 64'd1);
    end
    for (int d = 0; d < 5; d++) rdy[d] = 1'b1;
  endtask

  initial begin
    rst  = 1'b0;
    init = 1'b0;
    key  = '0;
    iv   = '0;
    for (int d = 0; d < 5; d++) rdy[d] = 1'b1;
    #3;
    check("rst_busy", 64'(bsy[0]), 64'd0);
    check("rst_valid", 64'(val[0]), 64'd0);
    check("rst_data", dat[0], 64'd0);
    check("rst_data64", dat[3], 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // basic load with all-zero key/iv
    start(80'h0, 80'h0);
    collect(1'b0);

    // width sweep with backpressure on the 8-bit variant
    start(80'h0123456789ABCDEF0123, 80'hFEDCBA9876543210FEDC);
    collect(1'b1);

    // re-init while a word is being handshaken
    start(80'h0123456789ABCDEF0123, 80'hFEDCBA9876543210FEDC);
    repeat (150) @(negedge clk);
    check("pre_reinit_valid", 64'(val[0]), 64'd1);
    check("pre_reinit_busy", 64'(bsy[0]), 64'd0);
    start(80'h3C5A96F01E2D4B78A5C3, 80'h0F1E2D3C4B5A69788796);
    check("reinit_valid", 64'(val[0]), 64'd0);
    check("reinit_busy", 64'(bsy[0]), 64'd1);
    collect(1'b0);

    // async reset mid warm-up
    start(80'hA5A5A5A5A5A5A5A5A5A5, 80'h123456789ABCDEF01234);
    repeat (50) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", 64'(bsy[0]), 64'd0);
    check("arst_valid", 64'(val[0]), 64'd0);
    check("arst_data", dat[0], 64'd0);
    check("arst_data16", dat[2], 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) begin
      key = 80'({$urandom, $urandom, $urandom});
      @(negedge clk);
    end
    check("idle_busy", 64'(bsy[0]), 64'd0);
    check("idle_valid", 64'(val[0]), 64'd0);
    check("idle_data", dat[0], 64'd0);
    check("idle_valid_short", 64'(val[4]), 64'd0);

    // recovery after reset
    start(80'hA5A5A5A5A5A5A5A5A5A5, 80'h123456789ABCDEF01234);
    collect(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trivium_parallel.md
Name: trivium_parallel

Overview:
- Parametrised successor of the team's serial Trivium core.
- Advances the 288-bit Trivium state OUT_WIDTH steps per clock and delivers OUT_WIDTH keystream bits per accepted word.
- Uses an explicit init/warm-up/run state machine and a valid/ready output stream.
- Sits between key/IV configuration logic and the stream-cipher XOR datapath. Its bit stream is identical to the serial core's for the same key/IV.

Parameters:
- OUT_WIDTH, 8, keystream bits per word and state steps per clock; legal values 1, 2, 4, 8, 16, 32, 64.
- WARMUP_ROUNDS, 1152, blank rounds before output; must be a non-zero multiple of OUT_WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- init  input  1  start pulse; key/iv sampled when init=1.
- key  input  80  cipher key.
- iv  input  80  initialisation vector.
- busy  output  1  high while in WARMUP.
- ks_valid  output  1  keystream word available.
- ks_ready  input  1  consumer accepts word.
- ks_data  output  OUT_WIDTH  keystream word; bit OUT_WIDTH-1 is the earliest bit.

Behaviour:
- Reset (rst=0, async): FSM=IDLE, all three registers (A 93b, B 84b, C 111b) cleared, warm-up counter=0, busy=0, ks_valid=0. ks_data is a function of state only, so it is 0 from the all-zero state.
- State layout and load values match the serial core:
  - A <= {13'b0,key}
  - B <= {4'b0,iv}
  - C <= {3'b111,108'b0}
  - Single-step update and taps are identical to the serial core.
  - Parallel step = OUT_WIDTH cascaded single steps, computed combinationally within one cycle.
- FSM states: IDLE, WARMUP, RUN.
- IDLE:
  - ks_valid=0, busy=0.
  - If init=1: load state from key/iv, counter<=0, go to WARMUP.
- WARMUP:
  - busy=1, ks_valid=0.
  - Each cycle: state advances OUT_WIDTH steps, counter++.
  - When counter = WARMUP_ROUNDS/OUT_WIDTH-1, the same edge moves to RUN.
  - Warm-up therefore lasts exactly WARMUP_ROUNDS/OUT_WIDTH cycles after the load edge.
- RUN:
  - ks_valid=1, busy=0.
  - ks_data[OUT_WIDTH-1-j] = output bit of step j (j=0..OUT_WIDTH-1) from the current state.
  - State advances OUT_WIDTH steps only when ks_valid & ks_ready.
  - While ks_ready=0, state and ks_data hold stable; no bit is ever lost or duplicated.
- init in WARMUP or RUN: the edge reloads state, clears counter, goes to WARMUP, and drops ks_valid the next cycle. A concurrent ks_ready handshake on that edge is discarded, so no state advance occurs. Init has priority.
- No combinational path from ks_ready to ks_data or ks_valid.
- Counter width: $clog2(WARMUP_ROUNDS/OUT_WIDTH+1); it never wraps (saturates by FSM exit).
- Key and iv are only sampled on init edges; changes at other times have no effect.
- Reset asserted mid-operation: immediate return to IDLE with all-zero state. init is required again.
- Equivalence: concatenating accepted ks_data words MSB-first equals the serial core's key_stream sequence after its warm-up, given the same key/iv.

Test Plan:
- Basic load:
  - Stimulus: rst low, then high; key=80'h0, iv=80'h0, init pulse; OUT_WIDTH=8, ks_ready=1.
  - Response: busy=1 for exactly 144 cycles, then ks_valid=1.
  - Check: the first 64 words equal the first 512 bits of a bit-accurate serial reference model.
- Width sweep:
  - Stimulus: OUT_WIDTH in {1,16,64}; key=80'h0123456789ABCDEF0123, iv=80'hFEDCBA9876543210FEDC.
  - Response: warm-up lasts 1152, 72 and 18 cycles respectively.
  - Check: the first 1024 bits are identical across all widths and identical to the serial model.
- Backpressure:
  - Stimulus: in RUN, toggle ks_ready pseudo-randomly (about 50%) for 500 cycles.
  - Response: ks_data stays stable while ks_ready=0.
  - Check: the accepted-word sequence equals the ks_ready=1 run.
- Re-init:
  - Stimulus: init with a new key while ks_valid=1 and ks_ready=1.
  - Response: next cycle ks_valid=0 and busy=1; no extra word is consumed.
  - Check: output afterwards matches a fresh run with the new key.
- Async reset:
  - Stimulus: assert rst=0 mid-WARMUP, between clock edges.
  - Response: busy=0, ks_valid=0 and ks_data=0 immediately, before the next edge.
  - Check: the block stays in IDLE until init.
- Short warm-up:
  - Stimulus: WARMUP_ROUNDS=64, OUT_WIDTH=64.
  - Response: exactly one warm-up cycle, then ks_valid=1.
